// File: rtl/pixel_gain_ctrl.sv
// Per-pixel RGB gain stage: button-driven gain level committed at start-of-frame, 2-stage multiply/saturate.
// Define GAIN_AUTOREPEAT_EN to build the held-button auto-repeat counter.
module pixel_gain_ctrl #(
  parameter int DW       = 8,
  parameter int LW       = 4,
  parameter int FRAC     = 3,
  parameter int PW       = 24,
  parameter int HOLD_CYC = 25000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          sof_in,
  input  logic          in_valid,
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] b,
  input  logic [PW-1:0] pass_in,
  output logic          out_valid,
  output logic [DW-1:0] outR,
  output logic [DW-1:0] outG,
  output logic [DW-1:0] outB,
  output logic [PW-1:0] pass_thru,
  output logic          sof_out,
  output logic [LW-1:0] level_out,
  output logic [LW-1:0] active_level_out
);

  localparam int PRW = DW + LW;
  localparam int QW  = PRW - FRAC;
  localparam logic [LW-1:0] LVL_MAX = '1;
  localparam logic [LW-1:0] LVL_RST = ((1 << FRAC) > (2**LW - 1)) ? LVL_MAX : LW'(1 << FRAC);

  if (HOLD_CYC < 1) begin : g_hold_chk
    $error("HOLD_CYC must be at least 1");
  end

  function automatic logic [DW-1:0] sat_scale(input logic [PRW-1:0] p);
    logic [QW-1:0] q;
    q = QW'(p >> FRAC);
    if (q > QW'(2**DW - 1)) return '1;
    return q[DW-1:0];
  endfunction

  logic          inc_q, dec_q;
  logic [LW-1:0] pend_q, pend_d, act_q, act_d;
  logic          inc_rise, dec_rise, step_up, step_dn;

  assign inc_rise = inc & ~inc_q;
  assign dec_rise = dec & ~dec_q;

`ifdef GAIN_AUTOREPEAT_EN
  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  logic [HC_W-1:0] hold_q, hold_d;
  logic            rep_up_q, rep_up_d, rep_dn_q, rep_dn_d;

  // The repeat request is registered and only honoured if the same button is still held alone.
  always_comb begin
    hold_d   = '0;
    rep_up_d = 1'b0;
    rep_dn_d = 1'b0;
    if ((inc ^ dec) && !inc_rise && !dec_rise) begin
      if (hold_q == HC_W'(HOLD_CYC - 1)) begin
        rep_up_d = inc;
        rep_dn_d = dec;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q   <= '0;
      rep_up_q <= 1'b0;
      rep_dn_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      rep_up_q <= rep_up_d;
      rep_dn_q <= rep_dn_d;
    end
  end

  assign step_up = (inc_rise & ~dec) | (rep_up_q & inc & ~dec);
  assign step_dn = (dec_rise & ~inc) | (rep_dn_q & dec & ~inc);
`else
  assign step_up = inc_rise & ~dec;
  assign step_dn = dec_rise & ~inc;
`endif

  // Commit takes the pending level as registered this cycle, so a same-cycle step waits a frame.
  always_comb begin
    pend_d = pend_q;
    if (step_up && pend_q != LVL_MAX)  pend_d = pend_q + 1'b1;
    else if (step_dn && pend_q != '0)  pend_d = pend_q - 1'b1;
    act_d = (in_valid && sof_in) ? pend_q : act_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      pend_q <= LVL_RST;
      act_q  <= LVL_RST;
    end else begin
      inc_q  <= inc;
      dec_q  <= dec;
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  assign level_out        = pend_q;
  assign active_level_out = act_q;

  // Stage 1: multiply by the next-state active level
  logic [PRW-1:0] mr_p1, mg_p1, mb_p1;
  logic [PW-1:0]  pass_p1;
  logic           vld_p1, sof_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      sof_p1 <= in_valid & sof_in;
    end
  end

  always_ff @(posedge clk) begin
    mr_p1   <= PRW'(r) * PRW'(act_d);
    mg_p1   <= PRW'(g) * PRW'(act_d);
    mb_p1   <= PRW'(b) * PRW'(act_d);
    pass_p1 <= pass_in;
  end

  // Stage 2: drop fractional bits and clip to channel range
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sof_out   <= 1'b0;
      outR      <= '0;
      outG      <= '0;
      outB      <= '0;
      pass_thru <= '0;
    end else begin
      out_valid <= vld_p1;
      sof_out   <= sof_p1;
      outR      <= sat_scale(mr_p1);
      outG      <= sat_scale(mg_p1);
      outB      <= sat_scale(mb_p1);
      pass_thru <= pass_p1;
    end
  end

endmodule

// File: doc/pixel_gain_ctrl.md
# pixel_gain_ctrl

Parametrised per-pixel gain stage for the RGB video path, sitting between the camera pixel stream and the downstream filter chain. It holds a user gain level driven by inc/dec buttons, with edge detection and optional auto-repeat. New levels are committed only at start-of-frame to avoid mid-frame tearing. The level is applied to R/G/B through a 2-stage multiply/saturate pipeline, with valid and sideband kept aligned.

## Interface
Parameters:
- DW, 8, channel width in bits
- LW, 4, level register width; levels 0 .. 2^LW-1
- FRAC, 3, fractional bits of level; unity gain = 1<<FRAC
- PW, 24, sideband pass-through width
- HOLD_CYC, 25000000, cycles a button must stay held before each auto-repeat step

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- inc  in  1  increase-level button, level-sensitive, already synchronised
- dec  in  1  decrease-level button, level-sensitive, already synchronised
- sof_in  in  1  start-of-frame marker, qualified by in_valid
- in_valid  in  1  input pixel valid
- r, g, b  in  DW each  input channels, unsigned
- pass_in  in  PW  sideband, delayed with the pixel
- out_valid  out  1  output pixel valid
- outR, outG, outB  out  DW each  scaled, saturated channels
- pass_thru  out  PW  pass_in aligned with the output pixel
- sof_out  out  1  sof_in aligned with the output pixel
- level_out  out  LW  pending level (user-visible)
- active_level_out  out  LW  level currently applied to pixels

## Operation
- Reset (rst_n=0 at clk edge): pending and active level = min(1<<FRAC, 2^LW-1). Hold counter, edge registers, out_valid, sof_out, outR/G/B and pass_thru = 0.
- Edge detect: inc_rise = inc & ~inc_q; dec_rise = dec & ~dec_q.
- Step rules, evaluated each cycle:
  - inc_rise alone: pending+1, saturating at 2^LW-1.
  - dec_rise alone: pending-1, saturating at 0.
  - inc and dec both high: no step, hold counter cleared.
  - Neither high: hold counter cleared.
- Commit: when in_valid & sof_in, active = pending value registered that cycle. A step in the same cycle lands next frame.
- Datapath stage 1: p = channel * active, width DW+LW, registered with valid/sof/pass.
- Datapath stage 2: q = p >> FRAC, truncated; out = (q > 2^DW-1) ? 2^DW-1 : q[DW-1:0], registered.
- Bubbles: in_valid=0 propagates as out_valid=0. Data on invalid beats is don't-care, but pass_thru still tracks the pipeline.

## Timing
- Pixel latency is exactly 2 cycles: out_valid(t+2) = in_valid(t). Same for outR/G/B, pass_thru and sof_out.
- Stall-free: one pixel accepted per cycle, no backpressure.
- level_out updates the cycle after the step edge.
- active_level_out updates the cycle after the committing sof beat. That sof pixel is already scaled by the new level (stage-1 multiply uses the next-state active level).
- Reset mid-frame: everything in the pipeline is discarded; outputs are 0 the cycle after reset is sampled.

## Configuration
- GAIN_AUTOREPEAT_EN defined:
  - While exactly one button stays high, the hold counter increments each cycle.
  - On reaching HOLD_CYC-1 it emits one additional step and restarts from 0.
  - Releasing the button or pressing both clears the counter.
  - Saturation limits still apply.
- Undefined: the hold counter is not instantiated and only rising edges step the level.

## Test plan
- Reset then r=200,g=100,b=17 with level 8 and sof -> after 2 cycles outR=200, outG=100, outB=17, out_valid=1, level_out=8.
- Single inc pulse, then pixels without sof -> level_out=9, active_level_out=8, outputs unchanged. Next sof beat with r=200 -> active=9, outR=225.
- 10 inc pulses from 8 then sof, r=200 -> level saturates at 15, outR=255 (3000>>3=375, clipped). 20 dec pulses then sof -> level 0, outR=0.
- inc and dec high together for 5 cycles -> level_out unchanged. in_valid toggling 1,0,1 with pass_in=0xA1B2C3 -> out_valid pattern 1,0,1 and pass_thru=0xA1B2C3 exactly 2 cycles later.
- GAIN_AUTOREPEAT_EN with HOLD_CYC=4, inc held 13 cycles from level 8 -> level_out=11 (edge step + 2 repeats). Same stimulus without the macro -> level_out=9.
- rst_n=0 for one cycle mid-frame with valid pixels in flight -> next cycle out_valid=0, outputs 0, level_out and active_level_out = 8.
